spi_rom_reader: RTL and testbench
=================================

Name: spi_rom_reader

Overview:
SPI flash burst reader sitting between the top-level SPI pins and the VGA pixel/row buffer logic. On a start strobe it issues a standard READ (0x03) command with a 24-bit address to an external SPI NOR flash. It then clocks in a fixed-length burst of bytes and presents them as one parallel word with a done pulse. SCLK runs at clk/2, mode 0.

Parameters:
BYTES, 10, payload bytes per burst (1..32)
CMD_READ, 8'h03, command byte shifted out first
ADDR_W, 24, address width shifted out MSB-first

Ports:
clk  in  1  system clock (pixel clock domain)
rst_n  in  1  asynchronous active-low reset
start  in  1  request a burst; sampled only in IDLE
addr  in  ADDR_W  flash byte address; latched when start is accepted
busy  out  1  high from the cycle after start is accepted until DONE completes
done  out  1  one-cycle pulse when data_out is valid
data_out  out  BYTES*8  burst data; byte 0 (at addr) in [BYTES*8-1 -: 8], MSB-first
spi_cs_n  out  1  flash chip select, active low
spi_sclk  out  1  SPI clock, idle low
spi_mosi  out  1  SPI data to flash
spi_miso  in  1  SPI data from flash

Behaviour:
- Reset (async, immediate): state=IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, data_out=0, counters=0. Reset mid-burst aborts at once; CS rises in the same instant; no partial done.
- States: IDLE -> CMD (8 bits) -> ADDR (ADDR_W bits) -> DATA (BYTES*8 bits) -> DONE (1 cycle) -> IDLE.
- IDLE: if start=1 at edge k, latch addr, load TX shift reg {CMD_READ, addr}, go to CMD. At edge k+1, spi_cs_n=0 and busy=1.
- Bit timing: each bit = 2 clk cycles.
  - Low phase: sclk=0; mosi holds the current TX MSB.
  - High phase: sclk=1.
  - At the edge ending the high phase: sample spi_miso (DATA state only), shift TX left, bit counter++.
  - MOSI therefore changes only while sclk is low; the first bit is valid one full phase before the first rising edge.
- Per-state bit counts: 8 in CMD, ADDR_W in ADDR, BYTES*8 in DATA. spi_mosi=0 throughout DATA.
- RX: shift-left register, miso enters at bit 0. After the final DATA bit, byte 0 sits in the top byte.
- Total SPI bits N = 8 + ADDR_W + 8*BYTES. With start accepted at edge 0:
  - CS low for cycles 1..2N.
  - At edge 2N+1: state=DONE, spi_cs_n=1, sclk=0, done=1, data_out updated, busy still 1.
  - At edge 2N+2: IDLE, busy=0, done=0.
  - Default: N=112, done at cycle 225.
- data_out updates only on entry to DONE and holds until the next DONE. It is never visible mid-shift; the RX shift reg is internal.
- start while busy: ignored, not queued.
- start asserted in the same cycle busy falls: accepted. CS-high gap is then at least 2 cycles (DONE plus the IDLE cycle).
- addr changes while busy: no effect.
- Address wrap is the flash's concern; the block does not increment addr.

Decomposition:
- Shared package spi_rom_pkg:
  - state enum {IDLE, CMD, ADDR, DATA, DONE}
  - CMD_READ = 8'h03
  - helper constant for total bit count
- Flat module; no sub-module. Phase toggle, bit counter and shift registers are each small.

Test Plan:
- Reset and idle: hold rst_n=0, then release -> spi_cs_n=1, spi_sclk=0, busy=0, done=0, data_out=0; no SCLK toggles for 50 cycles.
- Basic burst: flash model image has byte[a]=a[7:0]^8'hA5. Pulse start with addr=24'h000000 -> MOSI carries 03 00 00 00. done pulses exactly 225 cycles after start. data_out=80'hA5A4A7A6A1A0A3A2ADAC. CS rises with done.
- Non-zero address: addr=24'h012345 -> MOSI bits 03 01 23 45. data_out top byte = 8'h45^8'hA5 = 8'hE0.
- Start while busy: second start pulse at cycle 40 with a different addr -> ignored. Exactly one done, data from the first addr.
- Back-to-back: start held high continuously -> second burst accepted the cycle after busy falls. CS high for exactly 2 cycles between bursts; both results correct.
- Async reset mid-burst: assert rst_n=0 at cycle 100, no clk edge -> spi_cs_n=1 and busy=0 immediately. After release, no done; a fresh start completes normally.

Source files
------------

// File: rtl/spi_rom_pkg.sv
// rtl/spi_rom_pkg.sv - shared types and constants for the SPI flash burst reader
package spi_rom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    // Number of SPI bit slots in one burst: command, address, payload
    function automatic int unsigned total_bits(input int unsigned addr_w, input int unsigned bytes);
        return 8 + addr_w + 8 * bytes;
    endfunction

endpackage

// File: rtl/spi_rom_reader.sv
// rtl/spi_rom_reader.sv - SPI NOR READ (0x03) burst reader, mode 0, SCLK = clk/2
module spi_rom_reader
    import spi_rom_pkg::*;
#(
    parameter int unsigned BYTES    = 10,
    parameter logic [7:0]  CMD_READ = SPI_CMD_READ,
    parameter int unsigned ADDR_W   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    addr,
    output logic                 busy,
    output logic                 done,
    output logic [BYTES*8-1:0]   data_out,
    output logic                 spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int unsigned DATA_W = BYTES * 8;
    localparam int unsigned TX_W   = 8 + ADDR_W;
    localparam int unsigned N_BITS = total_bits(ADDR_W, BYTES);
    localparam int unsigned CNT_W  = $clog2(N_BITS + 1);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   data_q, data_d;

    // Next-state and registered-output logic; all pins come straight from flops
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;

        case (state_q)
            // DONE's only edge doubles as an IDLE sampling point, so a held
            // start relaunches with just two CS-high cycles between bursts
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = ST_CMD;
                    tx_d    = {CMD_READ, addr};
                    cnt_d   = '0;
                end
            end

            ST_CMD, ST_ADDR, ST_DATA: begin
                cs_n_d = 1'b0;
                busy_d = 1'b1;
                if (cs_n_q) begin
                    // First edge after acceptance: drop CS, present bit 0 in a low phase
                    sclk_d = 1'b0;
                    mosi_d = tx_q[TX_W-1];
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // End of high phase: sample, shift, advance bit count
                    sclk_d = 1'b0;
                    tx_d   = tx_q << 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (state_q == ST_DATA) begin
                        rx_d = {rx_q[DATA_W-2:0], spi_miso};
                    end
                    case (state_q)
                        ST_CMD: begin
                            if (cnt_q == CMD_LAST) begin
                                state_d = ST_ADDR;
                                cnt_d   = '0;
                            end
                        end
                        ST_ADDR: begin
                            if (cnt_q == ADDR_LAST) begin
                                state_d = ST_DATA;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            if (cnt_q == DATA_LAST) begin
                                state_d = ST_DONE;
                                cnt_d   = '0;
                                cs_n_d  = 1'b1;
                                done_d  = 1'b1;
                                data_d  = rx_d;
                            end
                        end
                    endcase
                    mosi_d = (state_d == ST_CMD || state_d == ST_ADDR) ? tx_q[TX_W-2] : 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts a burst with CS released at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_rom_reader.sv
// tb/tb_spi_rom_reader.sv - self-checking bench for spi_rom_reader with a behavioural flash
module tb_spi_rom_reader;

    localparam int BYTES = 10;
    localparam int DW    = BYTES * 8;
    localparam int LAT   = 2 * (8 + 24 + DW) + 1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic [23:0]   addr_i = '0;
    logic          busy, done, spi_cs_n, spi_sclk, spi_mosi;
    logic          spi_miso = 1'b0;
    logic [DW-1:0] data_out;

    always #5 clk = ~clk;

    spi_rom_reader #(.BYTES(BYTES), .CMD_READ(8'h03), .ADDR_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr_i),
        .busy(busy), .done(done), .data_out(data_out),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Flash image: byte[a] = a[7:0] ^ 0xA5
    function automatic logic [7:0] img(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic flash_bit(input int j, input logic [23:0] a);
        logic [23:0] ba;
        logic [7:0]  b;
        ba = a + 24'(j / 8);
        b  = img(ba);
        return b[7 - (j % 8)];
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [23:0] a);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < BYTES; i++) r = {r[DW-9:0], img(a + 24'(i))};
        return r;
    endfunction

    // Behavioural flash: records command/address, shifts data out on falling SCLK
    int          fbit = 0;
    logic [31:0] mosi_log = '0;
    always @(negedge spi_cs_n) begin
        fbit     = 0;
        mosi_log = '0;
    end
    always @(posedge spi_sclk) begin
        if (!spi_cs_n) begin
            if (fbit < 32) mosi_log = {mosi_log[30:0], spi_mosi};
            fbit++;
        end
    end
    always @(negedge spi_sclk) begin
        if (!spi_cs_n && fbit >= 32 && (fbit - 32) < DW) spi_miso = flash_bit(fbit - 32, mosi_log[23:0]);
    end

    int done_cnt = 0;
    int sclk_toggles = 0;
    int bad_mosi = 0;
    logic prev_mosi = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (spi_sclk === 1'b1 && spi_mosi !== prev_mosi) bad_mosi++;
        prev_mosi = spi_mosi;
    end
    always @(spi_sclk) sclk_toggles++;

    int acc = 0;

    task automatic launch(input logic [23:0] a, input bit hold);
        @(negedge clk);
        start  = 1'b1;
        addr_i = a;
        @(negedge clk);
        if (!hold) start = 1'b0;
        acc = cyc;
        @(negedge clk);
        check("cs_low_after_accept", spi_cs_n, 1'b0);
        check("busy_after_accept", busy, 1'b1);
        addr_i = 24'($urandom);
    endtask

    task automatic wait_done(input logic [23:0] a, input logic [23:0] next_a);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", 1'b0, 1'b1);
            return;
        end
        check("done_latency", 128'(cyc - acc), 128'(LAT));
        check("cs_high_at_done", spi_cs_n, 1'b1);
        check("busy_at_done", busy, 1'b1);
        check("sclk_low_at_done", spi_sclk, 1'b0);
        check("data_out", data_out, exp_data(a));
        check("mosi_cmd_addr", mosi_log, {8'h03, a});
        addr_i = next_a;
        @(negedge clk);
        acc = cyc;
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        check("data_hold", data_out, exp_data(a));
    endtask

    initial begin
        logic [23:0] a1, a2;
        int d0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sclk", spi_sclk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", data_out, '0);
        rst_n = 1'b1;
        sclk_toggles = 0;
        repeat (50) @(negedge clk);
        check("idle_no_sclk", sclk_toggles, 0);
        check("idle_cs_n", spi_cs_n, 1'b1);

        // Basic burst at address 0
        launch(24'h000000, 1'b0);
        wait_done(24'h000000, 24'h0);
        check("basic_value", data_out, 80'hA5A4A7A6A1A0A3A2ADAC);

        // Non-zero address
        launch(24'h012345, 1'b0);
        wait_done(24'h012345, 24'h0);
        check("top_byte", data_out[DW-1 -: 8], 8'hE0);

        // Start while busy is ignored
        a1 = 24'($urandom);
        a2 = a1 ^ 24'h5A5A5A;
        d0 = done_cnt;
        launch(a1, 1'b0);
        while (cyc < acc + 40) @(negedge clk);
        start  = 1'b1;
        addr_i = a2;
        @(negedge clk);
        start  = 1'b0;
        wait_done(a1, 24'h0);
        repeat (300) @(negedge clk);
        check("single_done", done_cnt - d0, 1);

        // Back-to-back with start held high
        a1 = 24'($urandom);
        a2 = 24'($urandom);
        launch(a1, 1'b1);
        wait_done(a1, a2);
        check("b2b_gap_cs_high", spi_cs_n, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_cs_low_again", spi_cs_n, 1'b0);
        wait_done(a2, 24'h0);

        // Asynchronous reset mid-burst
        a1 = 24'($urandom);
        d0 = done_cnt;
        launch(a1, 1'b0);
        while (cyc < acc + 100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", spi_cs_n, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_sclk", spi_sclk, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_data_cleared", data_out, '0);
        launch(a1, 1'b0);
        wait_done(a1, 24'h0);

        // Randomized bursts
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            a1 = 24'($urandom);
            launch(a1, 1'b0);
            wait_done(a1, 24'h0);
        end

        check("mosi_stable_while_sclk_high", bad_mosi, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
